// File: rtl/ps2_command_sequencer.sv
// ps2_command_sequencer: PS/2 host-to-device command sender with ACK/response handling and resend retries; CPU status/command registers, open-drain clock/data enables, receive inhibit.
module ps2_command_sequencer #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES = 50,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        status_cs,
  input  logic        command_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic        edge_found,
  input  logic        ps2_data_in,
  input  logic [7:0]  rx_scancode,
  input  logic        scancode_rx,
  output logic        ps2_clock_low,
  output logic        ps2_data_low,
  output logic        rx_inhibit
);
  localparam logic [2:0] IDLE = 3'd0, INHIBIT = 3'd1, RTS = 3'd2, SHIFT = 3'd3, ACK = 3'd4, RESP = 3'd5;
  logic [2:0] state;
  logic [31:0] cnt;
  logic [3:0] bitcnt;
  logic [7:0] cmd, response, retry;
  logic done, ack_err, timeout, resend_err, dlow, busy, tmo, unused;
  assign busy = state != IDLE;
  assign tmo = cnt >= 32'(TIMEOUT_CYCLES - 1);
  assign unused = ^data_in[23:0];
  assign data_out = status_cs ? {busy, done, ack_err, timeout, resend_err, 3'b0, response, 16'h0}
                  : command_cs ? {cmd, 24'h0} : 32'h0;
  assign data_out_valid = read && (status_cs || command_cs);
  assign ps2_clock_low = !reset && (state == INHIBIT || state == RTS);
  assign ps2_data_low = !reset && dlow;
  assign rx_inhibit = !reset && (state == INHIBIT || state == RTS || state == SHIFT || state == ACK);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bitcnt <= '0;
      cmd <= '0;
      response <= '0;
      retry <= '0;
      done <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
      resend_err <= 1'b0;
      dlow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (write && command_cs) begin
          cmd <= data_in[31:24];
          done <= 1'b0;
          ack_err <= 1'b0;
          timeout <= 1'b0;
          resend_err <= 1'b0;
          retry <= '0;
          cnt <= '0;
          state <= INHIBIT;
        end
        INHIBIT: if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
          cnt <= '0;
          dlow <= 1'b1;
          state <= RTS;
        end else cnt <= cnt + 1;
        RTS: if (cnt == 32'(RTS_CYCLES - 1)) begin
          cnt <= '0;
          bitcnt <= '0;
          state <= SHIFT;
        end else cnt <= cnt + 1;
        SHIFT: begin
          cnt <= cnt + 1;
          if (edge_found) begin
            bitcnt <= bitcnt + 4'd1;
            dlow <= bitcnt < 4'd8 ? ~cmd[bitcnt[2:0]] : bitcnt == 4'd8 ? ^cmd : 1'b0;
            if (bitcnt == 4'd9) state <= ACK;
          end else if (tmo) begin
            timeout <= 1'b1;
            dlow <= 1'b0;
            state <= IDLE;
          end
        end
        ACK: begin
          cnt <= cnt + 1;
          if (edge_found) begin
            if (!ps2_data_in) begin
              cnt <= '0;
              state <= RESP;
            end else begin
              ack_err <= 1'b1;
              state <= IDLE;
            end
          end else if (tmo) begin
            timeout <= 1'b1;
            state <= IDLE;
          end
        end
        RESP: begin
          cnt <= cnt + 1;
          if (scancode_rx) begin
            response <= rx_scancode;
            if (rx_scancode == 8'hFA) begin
              done <= 1'b1;
              state <= IDLE;
            end else if (rx_scancode == 8'hFE) begin
              if (retry < 8'(MAX_RETRIES)) begin
                retry <= retry + 8'd1;
                cnt <= '0;
                state <= INHIBIT;
              end else begin
                resend_err <= 1'b1;
                state <= IDLE;
              end
            end
          end else if (tmo) begin
            timeout <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_command_sequencer.sv
// tb_ps2_command_sequencer: directed device-model bench for ps2_command_sequencer.
module tb_ps2_command_sequencer;
  logic clock, reset, read, write, status_cs, command_cs, edge_found, ps2_data_in, scancode_rx;
  logic [31:0] data_in, data_out;
  logic [7:0] rx_scancode;
  logic data_out_valid, ps2_clock_low, ps2_data_low, rx_inhibit;
  int cmp = 0, bad = 0, frames = 0;
  logic [31:0] d;
  logic [10:0] f;
  ps2_command_sequencer #(.INHIBIT_CYCLES(20), .RTS_CYCLES(5), .TIMEOUT_CYCLES(300), .MAX_RETRIES(3)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .status_cs(status_cs),
    .command_cs(command_cs), .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid),
    .edge_found(edge_found), .ps2_data_in(ps2_data_in), .rx_scancode(rx_scancode),
    .scancode_rx(scancode_rx), .ps2_clock_low(ps2_clock_low), .ps2_data_low(ps2_data_low),
    .rx_inhibit(rx_inhibit));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input logic st, output logic [31:0] v);
    read = 1'b1;
    status_cs = st;
    command_cs = !st;
    #1 v = data_out;
    read = 1'b0;
    status_cs = 1'b0;
    command_cs = 1'b0;
  endtask
  task automatic cpu_write(input logic [31:0] v);
    @(negedge clock);
    write = 1'b1;
    command_cs = 1'b1;
    data_in = v;
    @(negedge clock);
    write = 1'b0;
    command_cs = 1'b0;
  endtask
  task automatic wait_release();
    int n = 0;
    while (!(ps2_data_low && !ps2_clock_low) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("release_seen", 32'(n < 2000), 32'd1);
  endtask
  task automatic pulse();
    edge_found = 1'b1;
    @(negedge clock);
    edge_found = 1'b0;
  endtask
  task automatic frame(input logic ack, output logic [10:0] fr);
    wait_release();
    check("rx_inh_shift", 32'(rx_inhibit), 32'd1);
    fr[0] = ~ps2_data_low;
    for (int i = 1; i <= 10; i++) begin
      pulse();
      fr[i] = ~ps2_data_low;
      repeat (3) @(negedge clock);
    end
    ps2_data_in = ack;
    pulse();
    ps2_data_in = 1'b1;
    frames++;
  endtask
  task automatic resp(input logic [7:0] b);
    rx_scancode = b;
    scancode_rx = 1'b1;
    @(negedge clock);
    scancode_rx = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    {read, write, status_cs, command_cs, edge_found, scancode_rx} = '0;
    ps2_data_in = 1'b1;
    data_in = '0;
    rx_scancode = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    rd(1'b1, d);
    check("rst_status", d, 32'h0);
    check("rst_lines", {29'd0, ps2_clock_low, ps2_data_low, rx_inhibit}, 32'h0);
    read = 1'b1;
    status_cs = 1'b1;
    #1 check("rd_valid", 32'(data_out_valid), 32'd1);
    read = 1'b0;
    status_cs = 1'b0;
    #1 check("rd_novalid", {data_out[0], data_out_valid}, 32'h0);
    cpu_write(32'hED00_0000);
    check("accept_latency", 32'(ps2_clock_low), 32'd1);
    cpu_write(32'h1200_0000);
    rd(1'b0, d);
    check("busy_write_ignored", d, 32'hED00_0000);
    rd(1'b1, d);
    check("busy_flag", d[31:24], 32'h80);
    frame(1'b0, f);
    check("frame_ed", 32'(f), 32'h7DA);
    check("rx_inh_resp", 32'(rx_inhibit), 32'd0);
    resp(8'hFA);
    rd(1'b1, d);
    check("status_ed", d, 32'h40FA_0000);
    cpu_write(32'h5500_0000);
    frame(1'b1, f);
    check("frame_55", 32'(f), 32'h6AA);
    rd(1'b1, d);
    check("status_ackerr", d, 32'h20FA_0000);
    check("lines_ackerr", {29'd0, ps2_clock_low, ps2_data_low, rx_inhibit}, 32'h0);
    frames = 0;
    cpu_write(32'hF400_0000);
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, f);
      check("frame_f4", 32'(f), 32'h5E8);
      resp(8'hFE);
    end
    repeat (30) @(negedge clock);
    check("resend_frames", 32'(frames), 32'd4);
    rd(1'b1, d);
    check("status_resend", d, 32'h08FE_0000);
    frames = 0;
    cpu_write(32'hFF00_0000);
    frame(1'b0, f);
    check("frame_ff", 32'(f), 32'h7FE);
    resp(8'hFE);
    frame(1'b0, f);
    resp(8'hFA);
    repeat (30) @(negedge clock);
    check("retry_frames", 32'(frames), 32'd2);
    rd(1'b1, d);
    check("status_retry", d, 32'h40FA_0000);
    cpu_write(32'hF300_0000);
    frame(1'b0, f);
    check("frame_f3", 32'(f), 32'h7E6);
    resp(8'hAA);
    rd(1'b1, d);
    check("unsolicited_busy", d[31:24], 32'h80);
    resp(8'hFA);
    rd(1'b1, d);
    check("status_after_aa", d, 32'h40FA_0000);
    cpu_write(32'h1100_0000);
    wait_release();
    begin
      int k = 0;
      status_cs = 1'b1;
      #1;
      while (!data_out[28] && k < 1000) begin
        @(negedge clock);
        #1 k++;
      end
      status_cs = 1'b0;
      check("timeout_cycles", 32'(k), 32'd300);
    end
    rd(1'b1, d);
    check("status_timeout", d[31:24], 32'h10);
    check("lines_timeout", {29'd0, ps2_clock_low, ps2_data_low, rx_inhibit}, 32'h0);
    cpu_write(32'h0000_0000);
    wait_release();
    repeat (3) pulse();
    check("pre_reset_data", 32'(ps2_data_low), 32'd1);
    reset = 1'b1;
    #1 check("reset_lines", {29'd0, ps2_clock_low, ps2_data_low, rx_inhibit}, 32'h0);
    rd(1'b1, d);
    check("reset_status", d, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
